// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encoding.
package div_pkg;
    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare with divisor, subtract if it fits.
// Pure combinational; relies on rem_in < dvsr so the result always fits in W bits.
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] dvsr,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, dvsr};
        // Bit W of the difference is set exactly when the divisor did not fit.
        q_bit   = ~diff[W];
        rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider: W+2 cycles per result, 1 cycle for divide-by-zero.
// One operation in flight; start is only honoured while ready is high, nothing is queued.
module seq_divider
    import div_pkg::*;
#(
    parameter int W    = DIV_W,
    parameter int CBIT = $clog2(W+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] dvdn,
    input  logic [W-1:0] dvsr,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dbz,
    output logic         ovf
);
    div_state_t state, state_nxt;

    logic [W-1:0]    rem_r;
    logic [W-1:0]    dvd_r;
    logic [W-1:0]    dvsr_r;
    logic [CBIT-1:0] cnt;
    logic            neg_q;
    logic            neg_r;
    logic            ovf_p;

    logic            dvdn_neg;
    logic            dvsr_neg;
    logic [W-1:0]    dvdn_mag;
    logic [W-1:0]    dvsr_mag;
    logic            accept;
    logic            min_by_neg1;
    logic [W-1:0]    step_rem;
    logic            step_q;

    always_comb begin
        dvdn_neg    = signed_mode & dvdn[W-1];
        dvsr_neg    = signed_mode & dvsr[W-1];
        dvdn_mag    = dvdn_neg ? -dvdn : dvdn;
        dvsr_mag    = dvsr_neg ? -dvsr : dvsr;
        accept      = (state == IDLE) && start;
        min_by_neg1 = signed_mode && (dvdn == {1'b1, {(W-1){1'b0}}}) && (dvsr == {W{1'b1}});
    end

    div_step #(.W(W)) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[W-1]),
        .dvsr    (dvsr_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (dvsr == '0) ? DONE : OP;
            OP:   if (cnt == CBIT'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Quotient bits shift into dvd_r as dividend bits shift out, so it holds the magnitude quotient after W steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= '0;
            dvd_r  <= '0;
            dvsr_r <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            ovf_p  <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                if (dvsr == '0) begin
                    quo <= '1;
                    rem <= dvdn;
                    dbz <= 1'b1;
                    ovf <= 1'b0;
                end else begin
                    rem_r  <= '0;
                    dvd_r  <= dvdn_mag;
                    dvsr_r <= dvsr_mag;
                    cnt    <= CBIT'(W);
                    neg_q  <= dvdn_neg ^ dvsr_neg;
                    neg_r  <= dvdn_neg;
                    ovf_p  <= min_by_neg1;
                end
            end
            if (state == OP) begin
                rem_r <= step_rem;
                dvd_r <= {dvd_r[W-2:0], step_q};
                cnt   <= cnt - CBIT'(1);
            end
            if (state == FIX) begin
                quo <= neg_q ? -dvd_r : dvd_r;
                rem <= neg_r ? -rem_r : rem_r;
                dbz <= 1'b0;
                ovf <= ovf_p;
            end
        end
    end

    assign ready     = (state == IDLE);
    assign done_tick = (state == DONE);
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at W=8: expected results queued at launch, compared at done_tick.
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dvdn;
    logic [W-1:0] dvsr;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic         ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dvdn        (dvdn),
        .dvsr        (dvsr),
        .ready       (ready),
        .done_tick   (done_tick),
        .quo         (quo),
        .rem         (rem),
        .dbz         (dbz),
        .ovf         (ovf)
    );

    function automatic exp_t model(input logic sm, input logic [7:0] a, input logic [7:0] b);
        exp_t m;
        int   sa;
        int   sb_i;
        m.dbz = 1'b0;
        m.ovf = 1'b0;
        m.lat = W + 2;
        if (b == 8'h00) begin
            m.q   = 8'hFF;
            m.r   = a;
            m.dbz = 1'b1;
            m.lat = 1;
        end else if (!sm) begin
            m.q = a / b;
            m.r = a % b;
        end else if (a == 8'h80 && b == 8'hFF) begin
            m.q   = 8'h80;
            m.r   = 8'h00;
            m.ovf = 1'b1;
        end else begin
            sa   = $signed(a);
            sb_i = $signed(b);
            m.q  = 8'(sa / sb_i);
            m.r  = 8'(sa % sb_i);
        end
        return m;
    endfunction

    task automatic launch(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL launch_ready: ready=%b, required 1", ready);
        end
        start       = 1'b1;
        signed_mode = sm;
        dvdn        = a;
        dvsr        = b;
        sb.push_back(model(sm, a, b));
        @(posedge clk);
        #1;
        start       = 1'b0;
        dvdn        = 8'($urandom);
        dvsr        = 8'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_tick && cyc < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dvdn = '0; dvsr = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ready, done_tick} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready,done=%b%b, required 10", ready, done_tick);
        end
        tests_run++;
        if ({quo, rem, dbz, ovf} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: quo=%h rem=%h dbz=%b ovf=%b, required all zero", quo, rem, dbz, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_table(input string name, input logic [7:0] sm_v, input logic [7:0] a_v [4], input logic [7:0] b_v [4], input int n);
        int   cyc;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            launch(sm_v[i], a_v[i], b_v[i]);
            wait_done(0, cyc);
            e = sb.pop_front();
            tests_run++;
            if ({quo, rem, dbz, ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
                tests_failed++;
                $display("FAIL %s[%0d] %h/%h: quo=%h rem=%h dbz=%b ovf=%b, required quo=%h rem=%h dbz=%b ovf=%b",
                         name, i, a_v[i], b_v[i], quo, rem, dbz, ovf, e.q, e.r, e.dbz, e.ovf);
            end
            tests_run++;
            if (cyc != e.lat) begin
                tests_failed++;
                $display("FAIL %s_latency[%0d]: %0d cycles, required %0d", name, i, cyc, e.lat);
            end
            @(negedge clk);
            tests_run++;
            if ({done_tick, ready} !== 2'b01) begin
                tests_failed++;
                $display("FAIL %s_pulse[%0d]: done,ready=%b%b after done, required 01", name, i, done_tick, ready);
            end
        end
    endtask

    task automatic test_unsigned();
        logic [7:0] a [4] = '{8'd200, 8'd255, 8'd9, 8'd0};
        logic [7:0] b [4] = '{8'd7, 8'd16, 8'd10, 8'd3};
        test_table("unsigned", 8'h00, a, b, 4);
    endtask

    task automatic test_signed();
        logic [7:0] a [4] = '{8'hF9, 8'h07, 8'hF9, 8'hF8};
        logic [7:0] b [4] = '{8'h02, 8'hFE, 8'hFE, 8'h04};
        test_table("signed", 8'h0F, a, b, 4);
    endtask

    task automatic test_dbz();
        logic [7:0] a [4] = '{8'h55, 8'h55, 8'h00, 8'h00};
        logic [7:0] b [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
        test_table("dbz", 8'h02, a, b, 2);
    endtask

    task automatic test_ovf();
        logic [7:0] a [4] = '{8'h80, 8'h80, 8'h00, 8'h00};
        logic [7:0] b [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        test_table("ovf", 8'h01, a, b, 2);
    endtask

    task automatic test_hold();
        int   cyc;
        exp_t prev;
        exp_t e;
        launch(1'b0, 8'd100, 8'd9);
        wait_done(0, cyc);
        prev = sb.pop_front();
        launch(1'b1, 8'hF9, 8'h02);
        for (int i = 0; i < 5; i++) @(negedge clk);
        tests_run++;
        if ({quo, rem} !== {prev.q, prev.r}) begin
            tests_failed++;
            $display("FAIL hold_during_op: quo=%h rem=%h, required quo=%h rem=%h", quo, rem, prev.q, prev.r);
        end
        wait_done(5, cyc);
        e = sb.pop_front();
        tests_run++;
        if ({quo, rem, cyc} !== {e.q, e.r, e.lat}) begin
            tests_failed++;
            $display("FAIL hold_next_result: quo=%h rem=%h lat=%0d, required quo=%h rem=%h lat=%0d", quo, rem, cyc, e.q, e.r, e.lat);
        end
    endtask

    task automatic test_ignore_start();
        int   cyc;
        int   extra;
        exp_t e;
        launch(1'b0, 8'd200, 8'd7);
        for (int i = 0; i < 3; i++) @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; dvdn = 8'h09; dvsr = 8'h03;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, cyc);
        e = sb.pop_front();
        tests_run++;
        if ({quo, rem, dbz, ovf, cyc} !== {e.q, e.r, e.dbz, e.ovf, e.lat}) begin
            tests_failed++;
            $display("FAIL ignore_start: quo=%h rem=%h lat=%0d, required quo=%h rem=%h lat=%0d", quo, rem, cyc, e.q, e.r, e.lat);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_tick) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL ignore_start_queued: %0d extra done_tick, required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int   seen;
        exp_t e;
        launch(1'b0, 8'd200, 8'd7);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({ready, done_tick, quo, rem} !== {1'b1, 1'b0, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_mid: ready=%b done=%b quo=%h rem=%h, required ready=1 done=0 quo=00 rem=00", ready, done_tick, quo, rem);
        end
        rst = 1'b0;
        e = sb.pop_front();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_tick) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_done: %0d done_tick after reset of %h/%h, required 0", seen, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back();
        int         cyc;
        exp_t       e;
        logic       sm;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if (i % 10 == 7) begin
                a = 8'h80;
                b = 8'hFF;
            end
            launch(sm, a, b);
            wait_done(0, cyc);
            e = sb.pop_front();
            tests_run++;
            if ({quo, rem, dbz, ovf, cyc} !== {e.q, e.r, e.dbz, e.ovf, e.lat}) begin
                tests_failed++;
                $display("FAIL b2b[%0d] sm=%b %h/%h: quo=%h rem=%h dbz=%b ovf=%b lat=%0d, required quo=%h rem=%h dbz=%b ovf=%b lat=%0d",
                         i, sm, a, b, quo, rem, dbz, ovf, cyc, e.q, e.r, e.dbz, e.ovf, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_dbz();
        test_ovf();
        test_hold();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter W, default 16, operand and result width (W >= 4).
REQ-002 SHALL have parameter CBIT, default $clog2(W+1), iteration counter width.
REQ-003 SHALL have port clk  input  1  clock; all flops rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a division; sampled only when ready=1.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port dvdn  input  W  dividend; sampled with start.
REQ-008 SHALL have port dvsr  input  W  divisor; sampled with start.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port done_tick  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port quo  output  W  registered quotient.
REQ-012 SHALL have port rem  output  W  registered remainder.
REQ-013 SHALL have port dbz  output  1  divide-by-zero flag for last result.
REQ-014 SHALL have port ovf  output  1  signed overflow flag for last result.

Function
REQ-015 SHALL implement states IDLE, OP, FIX, DONE.
REQ-016 IDLE with start=1 and dvsr!=0: SHALL latch operand magnitudes (absolute values when signed_mode=1), result signs, counter=W, then go to OP.
REQ-017 IDLE with start=1 and dvsr==0: SHALL go directly to DONE with quo=all ones, rem=dvdn unchanged, dbz=1, ovf=0.
REQ-018 OP: each cycle SHALL perform one restoring shift/compare/subtract step producing one quotient bit MSB-first, decrement counter, and go to FIX after exactly W cycles.
REQ-019 FIX: SHALL negate quotient if dividend and divisor signs differ, negate remainder if dividend negative (signed_mode=1 only), register quo/rem, go to DONE.
REQ-020 Signed results SHALL truncate toward zero; remainder sign SHALL follow dividend; rem==0 never negated.
REQ-021 Signed most-negative / -1 SHALL yield quo=most-negative, rem=0, ovf=1; ovf=0 in all other cases.
REQ-022 DONE: done_tick=1 for exactly one cycle, then IDLE unconditionally.
REQ-023 Latency start-accept edge to done_tick SHALL be W+2 cycles normal, 1 cycle divide-by-zero.
REQ-024 quo, rem, dbz, ovf SHALL hold their values from DONE until the next accepted start; they SHALL NOT change during OP/FIX of a new operation until FIX/DONE writes them.
REQ-025 start while ready=0 SHALL be ignored; no queuing.
REQ-026 Operand inputs changing after acceptance SHALL NOT affect the result.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, including mid-operation, discarding any partial result.
REQ-028 Reset values: ready=1 (IDLE), done_tick=0, quo=0, rem=0, dbz=0, ovf=0, counter=0.

Structure
REQ-029 State encoding and default W SHALL reside in shared package div_pkg.
REQ-030 One-bit compare/subtract step SHALL be combinational sub-module div_step (inputs partial remainder, shifted bit, divisor; outputs next remainder, quotient bit).

Verification (W=8)
REQ-031 Unsigned 200/7 -> quo=28, rem=4, dbz=0, done_tick exactly 10 cycles after start.
REQ-032 Signed -7/2 -> quo=0xFD (-3), rem=0xFF (-1); signed 7/-2 -> quo=0xFD, rem=0x01.
REQ-033 0x55/0 (either mode) -> quo=0xFF, rem=0x55, dbz=1, done_tick 1 cycle after start.
REQ-034 Signed 0x80/0xFF -> quo=0x80, rem=0x00, ovf=1; following unsigned 0x80/0xFF -> quo=0, rem=0x80, ovf=0.
REQ-035 start pulsed with new operands at OP cycle 3 -> ignored, original result delivered; rst asserted at OP cycle 4 -> ready=1 next cycle, quo=rem=0, no done_tick.
